// File: rtl/wb_write_port_arbiter_if.sv
// Request/response bundle between the two result sources and the write-port arbiter.
// The master side presents writes and stall; the slave side arbitrates and drives the write port.
interface wb_write_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  first_valid;
  logic [DATA_WIDTH-1:0] first_data;
  logic [ADDR_WIDTH-1:0] first_addr;
  logic                  first_ready;
  logic                  second_valid;
  logic [DATA_WIDTH-1:0] second_data;
  logic [ADDR_WIDTH-1:0] second_addr;
  logic                  second_ready;
  logic                  stall;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  signal;
  logic [1:0]            owner;

  modport master (
    output first_valid, first_data, first_addr,
    output second_valid, second_data, second_addr, stall,
    input  first_ready, second_ready, wr_en, wr_addr, wr_data, signal, owner
  );

  modport slave (
    input  first_valid, first_data, first_addr,
    input  second_valid, second_data, second_addr, stall,
    output first_ready, second_ready, wr_en, wr_addr, wr_data, signal, owner
  );
endinterface

// File: rtl/wb_write_port_arbiter.sv
// Register-file write-port arbiter: round-robin between two sources with a bounded burst,
// registering the winning write and the downstream mux select.
module wb_write_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned MAX_BURST  = 4
) (
  input logic                  clock,
  input logic                  reset,
  wb_write_port_arbiter_if.slave bus
);
  localparam int unsigned CntWidth = $clog2(MAX_BURST + 1);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MAX_BURST);

  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StOwnFirst  = 2'b01,
    StOwnSecond = 2'b10
  } state_e;

  state_e                r_state;
  logic [CntWidth-1:0]   r_burst_cnt;
  logic                  r_last_second;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_signal;

  logic                  w_win_first;
  logic                  w_win_second;
  logic                  w_continue;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  always_comb begin
    w_win_first  = 1'b0;
    w_win_second = 1'b0;
    if (!reset && !bus.stall) begin
      case (r_state)
        StOwnFirst: begin
          if (bus.first_valid && r_burst_cnt < MaxCnt) w_win_first = 1'b1;
          else if (bus.second_valid)                   w_win_second = 1'b1;
          else if (bus.first_valid)                    w_win_first = 1'b1;
        end
        StOwnSecond: begin
          if (bus.second_valid && r_burst_cnt < MaxCnt) w_win_second = 1'b1;
          else if (bus.first_valid)                     w_win_first = 1'b1;
          else if (bus.second_valid)                    w_win_second = 1'b1;
        end
        default: begin
          // Tie from idle goes to whichever source did not win last.
          if (bus.first_valid && bus.second_valid) begin
            w_win_first  = r_last_second;
            w_win_second = !r_last_second;
          end else begin
            w_win_first  = bus.first_valid;
            w_win_second = bus.second_valid;
          end
        end
      endcase
    end
  end

  // Burst only extends while the same owner is still under the limit; otherwise it restarts.
  assign w_continue = ((w_win_first && r_state == StOwnFirst) ||
                       (w_win_second && r_state == StOwnSecond)) && (r_burst_cnt < MaxCnt);
  assign w_addr     = w_win_first ? bus.first_addr : bus.second_addr;
  assign w_data     = w_win_first ? bus.first_data : bus.second_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= StIdle;
      r_burst_cnt   <= '0;
      r_last_second <= 1'b1;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_signal      <= 1'b0;
    end else if (w_win_first || w_win_second) begin
      r_wr_en       <= (w_addr != '0);
      r_wr_addr     <= w_addr;
      r_wr_data     <= w_data;
      r_signal      <= w_win_first;
      r_state       <= w_win_first ? StOwnFirst : StOwnSecond;
      r_last_second <= w_win_second;
      r_burst_cnt   <= w_continue ? r_burst_cnt + CntWidth'(1) : CntWidth'(1);
    end else begin
      r_wr_en <= 1'b0;
      if (!bus.stall && !bus.first_valid && !bus.second_valid) begin
        r_state     <= StIdle;
        r_burst_cnt <= '0;
      end
    end
  end

  assign bus.first_ready  = w_win_first;
  assign bus.second_ready = w_win_second;
  assign bus.wr_en        = r_wr_en;
  assign bus.wr_addr      = r_wr_addr;
  assign bus.wr_data      = r_wr_data;
  assign bus.signal       = r_signal;
  assign bus.owner        = r_state;
endmodule
